branch_predict_unit: RTL and testbench

//  Successor to the single-cycle branch/jump resolver: adds a direct-mapped branch history table (2-bit counters)
//  and branch target buffer for fetch-stage prediction. Resolves branches/jumps in EX, detects mispredicts,

---
 rtl/bpu_pkg.sv | 31 +++
 rtl/bpu_cond_eval.sv | 26 ++
 rtl/branch_predict_unit.sv | 153 +++++++++++++++
 tb/tb_branch_predict_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared constants for the branch predict unit: branch condition encodings,
// 2-bit counter states, FSM state codes and the saturating counter update.
package bpu_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != CNT_ST) res = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bpu_cond_eval.sv
// Combinational branch condition: FUNCTION3 selects which ALU compare flag
// (or its inverse) decides the branch. Zero latency, no flow control.
module bpu_cond_eval
  import bpu_pkg::*;
(
  input  logic [2:0] function3_i,
  input  logic       equal_i,
  input  logic       signed_lt_i,
  input  logic       unsigned_lt_i,
  output logic       cond_o
);

  always_comb begin
    cond_o = 1'b0;
    case (function3_i)
      F3_BEQ:  cond_o = equal_i;
      F3_BNE:  cond_o = ~equal_i;
      F3_BLT:  cond_o = signed_lt_i;
      F3_BGE:  cond_o = ~signed_lt_i;
      F3_BLTU: cond_o = unsigned_lt_i;
      F3_BGEU: cond_o = ~unsigned_lt_i;
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-stage BHT/BTB prediction plus EX-stage resolution, redirect and multi-cycle flush.
// Optional BPU_PERF_CNT_EN adds resolve / mispredict event counters.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] fetch_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  input  logic            branch_i,
  input  logic            jump_i,
  input  logic [2:0]      function3_i,
  input  logic            equal_i,
  input  logic            signed_lt_i,
  input  logic            unsigned_lt_i,
  input  logic [XLEN-1:0] branch_addr_i,
  input  logic [XLEN-1:0] alu_jump_imm_i,
  output logic            pcmux_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            reg_flush_o,
  output logic            mispredict_o
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]     br_count_o,
  output logic [31:0]     mispred_count_o
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam int CNT_W = $clog2(FLUSH_DEPTH + 1);

  logic [1:0]             bht_q     [BHT_ENTRIES];
  logic [BHT_ENTRIES-1:0] btb_vld_q;
  logic [TAG_W-1:0]       btb_tag_q [BHT_ENTRIES];
  logic [XLEN-1:0]        btb_tgt_q [BHT_ENTRIES];

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;

  assign f_idx = fetch_pc_i[IDX_W+1:2];
  assign f_tag = fetch_pc_i[XLEN-1:IDX_W+2];
  assign e_idx = ex_pc_i[IDX_W+1:2];
  assign e_tag = ex_pc_i[XLEN-1:IDX_W+2];

  assign pred_taken_o  = btb_vld_q[f_idx] & (btb_tag_q[f_idx] == f_tag) & bht_q[f_idx][1];
  assign pred_target_o = btb_tgt_q[f_idx];

  logic cond, is_cf, eval, resolve, taken, mispredict;
  logic [XLEN-1:0] target, seq_pc;

  bpu_cond_eval u_cond (
    .function3_i   (function3_i),
    .equal_i       (equal_i),
    .signed_lt_i   (signed_lt_i),
    .unsigned_lt_i (unsigned_lt_i),
    .cond_o        (cond)
  );

  // Non-control-flow instructions are still checked: a stale taken prediction on them must be undone.
  assign is_cf      = branch_i | jump_i;
  assign eval       = rst_ni & ex_valid_i & (state_q == ST_IDLE);
  assign resolve    = eval & is_cf;
  assign taken      = is_cf & (jump_i | (branch_i & cond));
  assign target     = jump_i ? alu_jump_imm_i : branch_addr_i;
  assign seq_pc     = ex_pc_i + XLEN'(4);
  assign mispredict = eval & ((taken != ex_pred_taken_i) |
                              (taken & (ex_pred_target_i != target)));

  assign pcmux_o       = mispredict;
  assign mispredict_o  = mispredict;
  assign redirect_pc_o = mispredict ? (taken ? target : seq_pc) : '0;
  assign reg_flush_o   = mispredict | (state_q == ST_FLUSH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mispredict && (FLUSH_DEPTH > 1)) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_DEPTH - 1);
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_WNT;
      btb_vld_q <= '0;
    end else if (resolve) begin
      bht_q[e_idx] <= jump_i ? CNT_ST : sat_update(bht_q[e_idx], taken);
      if (taken) btb_vld_q[e_idx] <= 1'b1;
    end
  end

  // Tag/target payload is qualified by btb_vld_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (resolve && taken) begin
      btb_tag_q[e_idx] <= e_tag;
      btb_tgt_q[e_idx] <= target;
    end
  end

`ifdef BPU_PERF_CNT_EN
  logic [31:0] br_count_q, mispred_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      if (resolve)    br_count_q      <= br_count_q + 32'd1;
      if (mispredict) mispred_count_q <= mispred_count_q + 32'd1;
    end
  end

  assign br_count_o      = br_count_q;
  assign mispred_count_o = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized bench for branch_predict_unit against a table-level reference model,
// plus directed scenarios with hand-computed expectations.
module tb_branch_predict_unit;

  localparam int XLEN = 32;
  localparam int NENT = 64;
  localparam int FD   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_pred_taken, branch, jump;
  logic [31:0] ex_pc, ex_pred_target, branch_addr, alu_jump_imm;
  logic [2:0]  function3;
  logic        equal, signed_lt, unsigned_lt;
  logic        pcmux, reg_flush, mispredict;
  logic [31:0] redirect_pc;
`ifdef BPU_PERF_CNT_EN
  logic [31:0] br_count, mispred_count;
`endif

  branch_predict_unit #(.XLEN(XLEN), .BHT_ENTRIES(NENT), .FLUSH_DEPTH(FD)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .fetch_pc_i       (fetch_pc),
    .pred_taken_o     (pred_taken),
    .pred_target_o    (pred_target),
    .ex_valid_i       (ex_valid),
    .ex_pc_i          (ex_pc),
    .ex_pred_taken_i  (ex_pred_taken),
    .ex_pred_target_i (ex_pred_target),
    .branch_i         (branch),
    .jump_i           (jump),
    .function3_i      (function3),
    .equal_i          (equal),
    .signed_lt_i      (signed_lt),
    .unsigned_lt_i    (unsigned_lt),
    .branch_addr_i    (branch_addr),
    .alu_jump_imm_i   (alu_jump_imm),
    .pcmux_o          (pcmux),
    .redirect_pc_o    (redirect_pc),
    .reg_flush_o      (reg_flush),
    .mispredict_o     (mispredict)
`ifdef BPU_PERF_CNT_EN
    ,
    .br_count_o       (br_count),
    .mispred_count_o  (mispred_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: per-slot counter value 0..3, valid, full-PC tag, target.
  int          bht_m [NENT];
  bit          vld_m [NENT];
  logic [31:0] tag_m [NENT];
  logic [31:0] tgt_m [NENT];
  int          flush_left;
  logic [31:0] brc_m, misc_m;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % NENT);
  endfunction

  function automatic logic [31:0] tagof(input logic [31:0] pc);
    return pc / (4 * NENT);
  endfunction

  function automatic void lookup(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int s;
    s  = slot(pc);
    t  = vld_m[s] && (tag_m[s] == tagof(pc)) && (bht_m[s] >= 2);
    tg = tgt_m[s];
  endfunction

  function automatic bit cond_of(input logic [2:0] f3, input bit eq, input bit slt, input bit ult);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4: return slt;
      3'd5: return !slt;
      3'd6: return ult;
      3'd7: return !ult;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_now(output bit mis, output logic [31:0] rpc, output bit fl,
                                    output bit res, output bit tk, output logic [31:0] tg);
    bit active, cf;
    active = rst_n && ex_valid && (flush_left == 0);
    cf     = branch || jump;
    res    = active && cf;
    tk     = cf && (jump || (branch && cond_of(function3, equal, signed_lt, unsigned_lt)));
    tg     = jump ? alu_jump_imm : branch_addr;
    mis    = active && ((tk != ex_pred_taken) || (tk && ex_pred_target != tg));
    rpc    = tk ? tg : ex_pc + 32'd4;
    fl     = mis || (flush_left > 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit mis, fl, res, tk;
    logic [31:0] rpc, tg;
    int s;
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) begin
        bht_m[i] = 1;
        vld_m[i] = 1'b0;
        tag_m[i] = '0;
        tgt_m[i] = '0;
      end
      flush_left = 0;
      brc_m = 0;
      misc_m = 0;
    end else begin
      model_now(mis, rpc, fl, res, tk, tg);
      if (res) begin
        s = slot(ex_pc);
        if (jump) bht_m[s] = 3;
        else if (tk) bht_m[s] = (bht_m[s] < 3) ? bht_m[s] + 1 : 3;
        else bht_m[s] = (bht_m[s] > 0) ? bht_m[s] - 1 : 0;
        if (tk) begin
          vld_m[s] = 1'b1;
          tag_m[s] = tagof(ex_pc);
          tgt_m[s] = tg;
        end
        brc_m = brc_m + 1;
      end
      if (mis) begin
        misc_m = misc_m + 1;
        flush_left = FD - 1;
      end else if (flush_left > 0) begin
        flush_left = flush_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    bit mis, fl, res, tk, pt;
    logic [31:0] rpc, tg, ptg;
    if (rst_n && chk_en) begin
      model_now(mis, rpc, fl, res, tk, tg);
      lookup(fetch_pc, pt, ptg);
      check("pred_taken", pred_taken, pt);
      if (pt) check("pred_target", pred_target, ptg);
      check("pcmux", pcmux, mis);
      check("mispredict", mispredict, mis);
      check("reg_flush", reg_flush, fl);
      if (mis) check("redirect_pc", redirect_pc, rpc);
`ifdef BPU_PERF_CNT_EN
      check("br_count", br_count, brc_m);
      check("mispred_count", mispred_count, misc_m);
`endif
    end
  end

  task automatic idle_in();
    ex_valid = 0; branch = 0; jump = 0; ex_pred_taken = 0; ex_pred_target = 0;
    ex_pc = 0; function3 = 0; equal = 0; signed_lt = 0; unsigned_lt = 0;
    branch_addr = 0; alu_jump_imm = 0;
  endtask

  task automatic set_beq(input logic [31:0] pc, input bit eq, input logic [31:0] ba,
                         input bit pt, input logic [31:0] ptg);
    idle_in();
    ex_valid = 1; branch = 1; function3 = 3'b000; equal = eq;
    ex_pc = pc; branch_addr = ba; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit pt;
    logic [31:0] ptg;
    int kind;
    idle_in();
    fetch_pc = 32'h100;
    #1;
    check("rst_pred_taken", pred_taken, 0);
    check("rst_reg_flush", reg_flush, 0);
    check("rst_pcmux", pcmux, 0);
    check("rst_mispredict", mispredict, 0);
    check("rst_redirect", redirect_pc, 0);
    #11 rst_n = 1'b1;
    chk_en = 1'b1;

    // BEQ taken, predicted not-taken
    next_cycle();
    set_beq(32'h100, 1, 32'h140, 0, 0);
    #2;
    check("beq_pcmux", pcmux, 1);
    check("beq_redirect", redirect_pc, 32'h140);
    check("beq_flush0", reg_flush, 1);
    next_cycle();
    idle_in();
    #2;
    check("beq_flush1", reg_flush, 1);
    check("beq_flush_pcmux", pcmux, 0);
    next_cycle();
    #2;
    check("beq_flush_done", reg_flush, 0);
    check("beq_pred_taken", pred_taken, 1);
    check("beq_pred_target", pred_target, 32'h140);

    // Correctly predicted, then falls through
    next_cycle();
    set_beq(32'h100, 1, 32'h140, 1, 32'h140);
    #2;
    check("beq_hit_pcmux", pcmux, 0);
    check("beq_hit_flush", reg_flush, 0);
    next_cycle();
    set_beq(32'h100, 0, 32'h140, 1, 32'h140);
    #2;
    check("beq_nt_mis", mispredict, 1);
    check("beq_nt_redirect", redirect_pc, 32'h104);
    next_cycle();
    idle_in();
    next_cycle();
    #2;
    check("beq_weak_taken", pred_taken, 1);
    fetch_pc = 32'h200;
    #1;
    check("alias_miss", pred_taken, 0);

    // JAL, then a branch presented during the flush must be ignored
    next_cycle();
    idle_in();
    ex_valid = 1; jump = 1; ex_pc = 32'h200; alu_jump_imm = 32'h300;
    #2;
    check("jal_redirect", redirect_pc, 32'h300);
    check("jal_pcmux", pcmux, 1);
    next_cycle();
    set_beq(32'h180, 1, 32'h1c0, 0, 0);
    #2;
    check("flush_squash_pcmux", pcmux, 0);
    check("flush_squash_mis", mispredict, 0);
    check("flush_squash_flush", reg_flush, 1);
    next_cycle();
    idle_in();
    fetch_pc = 32'h180;
    #2;
    check("squashed_no_update", pred_taken, 0);
    fetch_pc = 32'h200;
    #1;
    check("jal_pred_taken", pred_taken, 1);
    check("jal_pred_target", pred_target, 32'h300);
    fetch_pc = 32'h100;
    #1;
    check("jal_evicts_alias", pred_taken, 0);

    // Reset in the middle of a flush
    next_cycle();
    set_beq(32'h40, 1, 32'h80, 0, 0);
    next_cycle();
    idle_in();
    #1;
    check("pre_rst_flush", reg_flush, 1);
    rst_n = 1'b0;
    #1;
    check("midflush_rst_flush", reg_flush, 0);
    check("midflush_rst_pcmux", pcmux, 0);
    check("midflush_rst_pred", pred_taken, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Three branches, two mispredicts
    next_cycle();
    set_beq(32'h40, 1, 32'h80, 0, 0);
    next_cycle();
    idle_in();
    next_cycle();
    set_beq(32'h40, 1, 32'h80, 1, 32'h80);
    next_cycle();
    set_beq(32'h40, 0, 32'h80, 1, 32'h80);
    next_cycle();
    idle_in();
    #2;
`ifdef BPU_PERF_CNT_EN
    check("perf_br_count", br_count, 3);
    check("perf_mispred_count", mispred_count, 2);
`endif
    check("perf_flush", reg_flush, 1);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      idle_in();
      fetch_pc = 32'($urandom_range(0, 511)) << 2;
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_pc = 32'($urandom_range(0, 511)) << 2;
      kind = $urandom_range(0, 3);
      branch = (kind == 0) || (kind == 2);
      jump = (kind == 1) || (kind == 2);
      function3 = 3'($urandom_range(0, 7));
      equal = 1'($urandom_range(0, 1));
      signed_lt = 1'($urandom_range(0, 1));
      unsigned_lt = 1'($urandom_range(0, 1));
      branch_addr = 32'($urandom_range(0, 1023)) << 2;
      alu_jump_imm = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 1) == 0) begin
        lookup(ex_pc, pt, ptg);
        ex_pred_taken = pt;
        ex_pred_target = ptg;
      end else begin
        ex_pred_taken = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
          0: ex_pred_target = branch_addr;
          1: ex_pred_target = alu_jump_imm;
          default: ex_pred_target = 32'($urandom_range(0, 1023)) << 2;
        endcase
      end
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        check("rand_rst_flush", reg_flush, 0);
        check("rand_rst_pcmux", pcmux, 0);
        rst_n = 1'b1;
      end
    end

    next_cycle();
    idle_in();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
